uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter that replaces fixed-ROM bit streaming with host-fed, framed serial output. Bytes written over a valid/ready interface are buffered in a small FIFO. Each byte is then serialised as start bit, LSB-first data, optional parity, and 1 or 2 stop bits, at a baud rate set by an integer clock divider. It sits between any on-chip message source and the board's serial pin.

## Interface
- CLK_DIV, 16, clock cycles per bit period; legal range ≥ 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, PAR_NONE, one of PAR_NONE / PAR_EVEN / PAR_ODD.
- STOP_BITS, 1, legal values 1 or 2.
- FIFO_DEPTH, 4, legal values are powers of two ≥ 2.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO can accept; equals !full.
- serialOut  out  1  line output; idle level is high.
- busy  out  1  a frame is in progress, or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of entries held.

## Operation
- Push: a push occurs at a rising edge where tx_valid && tx_ready. tx_data is captured at that edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: serialOut = 1. If the FIFO is non-empty, pop the head into shift register sh, clear the parity accumulator, load bit_cnt = 0, and go to START.
- START: serialOut = 0 for one bit period, then go to DATA.
- DATA: serialOut = sh[0], LSB first.
  - Each bit period: shift sh right, XOR the sent bit into the accumulator, increment bit_cnt.
  - After DATA_BITS bits, go to PARITY if PARITY != PAR_NONE, otherwise go to STOP.
- PARITY: serialOut = accumulator for PAR_EVEN, or ~accumulator for PAR_ODD, for one bit period. Then go to STOP.
- STOP: serialOut = 1 for STOP_BITS bit periods.
  - On the final bit-period end, if the FIFO is non-empty, pop and go directly to START (no idle gap).
  - Otherwise go to IDLE.
- Baud counter: counts 0..CLK_DIV-1 and is held at 0 in IDLE. The bit-period end is the cycle where it equals CLK_DIV-1.
- Width rules:
  - The baud counter is $clog2(CLK_DIV) bits.
  - bit_cnt is $clog2(DATA_BITS+1) bits.
  - fifo_count saturates at neither end; the handshake prevents overflow and underflow.
- Simultaneous push and pop in the same cycle: fifo_count is unchanged. When full, tx_ready = 0, so no push occurs.
- Reset values, mid-frame or otherwise: serialOut = 1, tx_ready = 1, busy = 0, fifo_count = 0, FSM = IDLE. The FIFO contents are discarded and the frame is truncated immediately.

## Timing
- Push at edge N into an idle, empty block:
  - fifo_count = 1 after edge N.
  - Pop, and START with serialOut = 0, after edge N+1.
  - fifo_count returns to 0 after edge N+1.
- Every line bit is exactly CLK_DIV cycles long.
- Frame length F = CLK_DIV × (1 + DATA_BITS + (PARITY != PAR_NONE) + STOP_BITS) cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- tx_ready is a registered-state function (!full) with no combinational path from tx_valid.
- serialOut is driven from a flop, so it is glitch-free.

## Structure
- Package uart_pkg:
  - enum parity_t {PAR_NONE, PAR_EVEN, PAR_ODD}.
  - enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
- Sub-module uart_fifo(WIDTH, DEPTH):
  - Synchronous FIFO with push/pop, full/empty, count.
  - Uses an extra-bit read/write pointer scheme.
  - Same clock and asynchronous reset as the parent.
- The top level holds the FSM, baud counter, shift register and parity accumulator.

## Test plan
- Reset then idle, CLK_DIV=4, 8N1: serialOut stays 1 for 100 cycles; tx_ready = 1, busy = 0, fifo_count = 0.
- 8E1, CLK_DIV=4, push 0xA5:
  - Line reads 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles.
  - The parity bit is 0.
  - 44 cycles total; busy drops after the last stop cycle.
- 8O2, push 0x01: parity bit = 0, followed by two stop periods; frame is 12 bit periods.
- Depth 4, hold tx_valid with 6 bytes 0x10..0x15 while idle:
  - tx_ready falls once 4 entries are queued alongside the active frame.
  - All 6 bytes are sent in order with no inter-frame gap.
- Assert reset mid-DATA of 0x3C with 2 bytes queued: serialOut = 1 and fifo_count = 0 immediately; nothing is sent afterwards.
- Push and pop in the same cycle with fifo_count = 2: fifo_count stays 2, and order is preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: parity mode selection and transmit FSM states.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO using extra-bit read/write pointers; full, empty and count are derived
// from the pointer difference.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    // Same slot index but opposite wrap bit means the writer has lapped the reader.
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop
// bits, with back-to-back frames when more data is queued.
module uart_tx_fifo #(
    parameter int unsigned        CLK_DIV    = 16,
    parameter int unsigned        DATA_BITS  = 8,
    parameter uart_pkg::parity_t  PARITY     = uart_pkg::PAR_NONE,
    parameter int unsigned        STOP_BITS  = 1,
    parameter int unsigned        FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          serialOut,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // The parameter PARITY shadows the state name, so that state is always package-qualified.
    import uart_pkg::*;

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam int unsigned BitW = $clog2(DATA_BITS + 1);

    tx_state_t              r_state, w_state_next;
    logic [CntW-1:0]        r_baud, w_baud_next;
    logic [BitW-1:0]        r_bit_cnt, w_bit_cnt_next;
    logic [DATA_BITS-1:0]   r_sh, w_sh_next;
    logic                   r_acc, w_acc_next;
    logic                   r_serial, w_serial_next;
    logic                   w_bit_end;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [DATA_BITS-1:0]   w_fifo_data;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (clock),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  (tx_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign w_push    = tx_valid && !w_full;
    assign w_bit_end = (r_baud == CntW'(CLK_DIV - 1));
    assign tx_ready  = !w_full;
    assign busy      = (r_state != IDLE) || !w_empty;
    assign serialOut = r_serial;

    always_comb begin
        w_state_next   = r_state;
        w_sh_next      = r_sh;
        w_acc_next     = r_acc;
        w_bit_cnt_next = r_bit_cnt;
        w_pop          = 1'b0;
        w_baud_next    = (r_state == IDLE || w_bit_end) ? '0 : r_baud + 1'b1;

        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_sh_next      = w_fifo_data;
                    w_acc_next     = 1'b0;
                    w_bit_cnt_next = '0;
                    w_state_next   = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_sh_next      = r_sh >> 1;
                    w_acc_next     = r_acc ^ r_sh[0];
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == BitW'(DATA_BITS - 1)) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == BitW'(STOP_BITS - 1)) begin
                        if (!w_empty) begin
                            w_pop          = 1'b1;
                            w_sh_next      = w_fifo_data;
                            w_acc_next     = 1'b0;
                            w_bit_cnt_next = '0;
                            w_state_next   = START;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Line level is decoded from next-state values so the output flop lines up with the state.
        case (w_state_next)
            START:            w_serial_next = 1'b0;
            DATA:             w_serial_next = w_sh_next[0];
            uart_pkg::PARITY: w_serial_next = (PARITY == PAR_ODD) ? ~w_acc_next : w_acc_next;
            default:          w_serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_sh      <= '0;
            r_acc     <= 1'b0;
            r_serial  <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_sh      <= w_sh_next;
            r_acc     <= w_acc_next;
            r_serial  <= w_serial_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: an 8E1 instance checked by a line monitor against queued
// frames, plus an 8O2 instance checked bit by bit.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CLK_DIV = 4;

    typedef struct packed {
        logic [10:0] line;
        logic        b2b;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [7:0] tx_data_e, tx_data_o;
    logic       tx_valid_e, tx_valid_o;
    logic       tx_ready_e, tx_ready_o;
    logic       serial_e, serial_o;
    logic       busy_e, busy_o;
    logic [2:0] count_e, count_o;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    uart_tx_fifo #(
        .CLK_DIV    (CLK_DIV),
        .DATA_BITS  (8),
        .PARITY     (PAR_EVEN),
        .STOP_BITS  (1),
        .FIFO_DEPTH (4)
    ) dut_e (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data_e),
        .tx_valid   (tx_valid_e),
        .tx_ready   (tx_ready_e),
        .serialOut  (serial_e),
        .busy       (busy_e),
        .fifo_count (count_e)
    );

    uart_tx_fifo #(
        .CLK_DIV    (CLK_DIV),
        .DATA_BITS  (8),
        .PARITY     (PAR_ODD),
        .STOP_BITS  (2),
        .FIFO_DEPTH (4)
    ) dut_o (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data_o),
        .tx_valid   (tx_valid_o),
        .tx_ready   (tx_ready_o),
        .serialOut  (serial_o),
        .busy       (busy_o),
        .fifo_count (count_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // 8E1 line image, index 0 = start bit.
    function automatic logic [10:0] frame_e(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    task automatic expect_frame(input logic [10:0] l, input logic b2b);
        exp_t e;
        e.line = l;
        e.b2b  = b2b;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle_e();
        int n;
        n = 0;
        while (busy_e && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle", busy_e, 0);
        repeat (5) @(negedge clock);
    endtask

    // Monitor: decodes each frame on serial_e and checks it against the scoreboard queue.
    initial begin : mon_e
        int          t;
        int          t_start;
        int          t_end;
        logic [10:0] got_line;
        logic        smp;
        bit          aborted;
        bit          glitch;
        exp_t        e;
        t     = 0;
        t_end = -1000;
        forever begin
            @(negedge clock);
            t++;
            if (!reset && serial_e === 1'b0) begin
                t_start = t;
                aborted = 0;
                glitch  = 0;
                for (int b = 0; b < 11; b++) begin
                    for (int c = 0; c < CLK_DIV; c++) begin
                        if (b != 0 || c != 0) begin
                            @(negedge clock);
                            t++;
                        end
                        if (reset) aborted = 1;
                        smp = serial_e;
                        if (c == 0) got_line[b] = smp;
                        else if (smp !== got_line[b]) glitch = 1;
                    end
                end
                if (aborted) begin
                    t_end = -1000;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got line 0x%0h, expected no frame", got_line);
                    t_end = t;
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_line", got_line, e.line);
                    chk("bit_width_stable", glitch, 0);
                    if (e.b2b) chk("b2b_gap", t_start - t_end, 1);
                    t_end = t;
                end
            end
        end
    end

    initial begin : stim
        int          zeros;
        int          i;
        int          n;
        int          highs;
        bit          seen_full;
        logic [11:0] want_o;

        reset      = 1'b1;
        tx_valid_e = 1'b0;
        tx_data_e  = '0;
        tx_valid_o = 1'b0;
        tx_data_o  = '0;
        repeat (3) @(negedge clock);
        chk("rst_serial", serial_e, 1);
        chk("rst_ready", tx_ready_e, 1);
        chk("rst_busy", busy_e, 0);
        chk("rst_count", count_e, 0);
        reset = 1'b0;

        // Idle line stays high.
        zeros = 0;
        repeat (100) begin
            @(negedge clock);
            if (serial_e !== 1'b1) zeros++;
        end
        chk("idle_low_cycles", zeros, 0);
        chk("idle_ready", tx_ready_e, 1);
        chk("idle_busy", busy_e, 0);
        chk("idle_count", count_e, 0);

        // Single 0xA5 frame: 0,1,0,1,0,0,1,0,1,0,1.
        tx_data_e  = 8'hA5;
        tx_valid_e = 1'b1;
        expect_frame(11'b1_0_1010_0101_0, 1'b0);
        @(negedge clock);
        tx_valid_e = 1'b0;
        chk("a5_count_after_push", count_e, 1);
        chk("a5_line_before_start", serial_e, 1);
        @(negedge clock);
        chk("a5_start_bit", serial_e, 0);
        chk("a5_count_after_pop", count_e, 0);
        chk("a5_busy_in_frame", busy_e, 1);
        repeat (43) @(negedge clock);
        chk("a5_busy_last_stop", busy_e, 1);
        chk("a5_line_last_stop", serial_e, 1);
        @(negedge clock);
        chk("a5_busy_after_frame", busy_e, 0);

        // Burst of six bytes with tx_valid held.
        wait_idle_e();
        i = 0;
        n = 0;
        seen_full = 0;
        while (i < 6 && n < 2000) begin
            tx_data_e  = 8'h10 + 8'(i);
            tx_valid_e = 1'b1;
            if (tx_ready_e) begin
                expect_frame(frame_e(8'h10 + 8'(i)), i != 0);
                i++;
            end else if (!seen_full) begin
                seen_full = 1;
                chk("burst_count_when_not_ready", count_e, 4);
                chk("burst_busy_when_full", busy_e, 1);
            end
            @(negedge clock);
            n++;
        end
        tx_valid_e = 1'b0;
        chk("burst_accepted", i, 6);
        chk("burst_saw_full", seen_full, 1);

        // Push coinciding with pop while two entries are queued.
        wait_idle_e();
        tx_data_e  = 8'h5A;
        tx_valid_e = 1'b1;
        expect_frame(frame_e(8'h5A), 1'b0);
        @(negedge clock);
        tx_data_e = 8'hC3;
        expect_frame(frame_e(8'hC3), 1'b1);
        @(negedge clock);
        chk("pp_count_first_overlap", count_e, 1);
        tx_data_e = 8'h96;
        expect_frame(frame_e(8'h96), 1'b1);
        @(negedge clock);
        tx_valid_e = 1'b0;
        chk("pp_count_two", count_e, 2);
        repeat (42) @(negedge clock);
        chk("pp_count_before", count_e, 2);
        chk("pp_line_last_stop", serial_e, 1);
        tx_data_e  = 8'h3F;
        tx_valid_e = 1'b1;
        expect_frame(frame_e(8'h3F), 1'b1);
        @(negedge clock);
        tx_valid_e = 1'b0;
        chk("pp_count_after", count_e, 2);
        chk("pp_next_start", serial_e, 0);

        // Reset during the data bits of 0x3C with two more bytes queued.
        wait_idle_e();
        tx_data_e  = 8'h3C;
        tx_valid_e = 1'b1;
        @(negedge clock);
        tx_data_e = 8'h81;
        @(negedge clock);
        tx_data_e = 8'h7E;
        @(negedge clock);
        tx_valid_e = 1'b0;
        chk("rst_mid_queued", count_e, 2);
        repeat (8) @(negedge clock);
        chk("rst_mid_data_bit", serial_e, 0);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_serial", serial_e, 1);
        chk("rst_mid_count", count_e, 0);
        chk("rst_mid_ready", tx_ready_e, 1);
        chk("rst_mid_busy", busy_e, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        zeros = 0;
        repeat (150) begin
            @(negedge clock);
            if (serial_e !== 1'b1) zeros++;
        end
        chk("rst_after_low_cycles", zeros, 0);
        chk("rst_after_busy", busy_e, 0);

        // 8O2 frame of 0x01: parity 0, two stop bits, 12 bit periods.
        want_o     = 12'b1_1_0_0000_0001_0;
        tx_data_o  = 8'h01;
        tx_valid_o = 1'b1;
        @(negedge clock);
        tx_valid_o = 1'b0;
        chk("o_count_after_push", count_o, 1);
        @(negedge clock);
        for (int b = 0; b < 12; b++) begin
            highs = 0;
            for (int c = 0; c < CLK_DIV; c++) begin
                if (serial_o === 1'b1) highs++;
                if (b == 11 && c == CLK_DIV - 1) chk("o_busy_last_cycle", busy_o, 1);
                @(negedge clock);
            end
            chk($sformatf("o_bit%0d_high_cycles", b), highs, want_o[b] ? CLK_DIV : 0);
        end
        chk("o_busy_after_frame", busy_o, 0);
        chk("o_line_after_frame", serial_o, 1);

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
